// File: rtl/switch_conditioner.sv
// Operator switch front end: synchronises ModeSel/TimeControl into clk,
// debounces every bit independently, loads the switch positions directly at
// start-up and strobes change_pulse on each accepted change.
module switch_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ModeSel_raw,
  input  logic [2:0] TimeControl_raw,
  output logic       ModeSel,
  output logic [2:0] TimeControl,
  output logic       change_pulse,
  output logic       ready
);

  // Per-bit debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Start-up counter must reach SYNC_STAGES+DEBOUNCE_CYCLES-1.
  localparam int SW = $clog2(SYNC_STAGES + DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] START_MAX = SW'(SYNC_STAGES + DEBOUNCE_CYCLES - 1);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  // Bit 3 carries ModeSel, bits 2:0 carry TimeControl.
  logic [3:0]                   raw;
  logic [SYNC_STAGES-1:0][3:0]  sync_chain;
  logic [3:0]                   sync_last;

  state_t                       state, state_nx;
  logic [SW-1:0]                start_cnt, start_cnt_nx;
  logic [3:0]                   clean, clean_nx;
  logic [3:0][CW-1:0]           cnt, cnt_nx;
  logic                         pulse_nx;
  logic                         ready_nx;

  assign raw       = {ModeSel_raw, TimeControl_raw};
  assign sync_last = sync_chain[SYNC_STAGES-1];

  assign ModeSel     = clean[3];
  assign TimeControl = clean[2:0];

  // Multi-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain <= '0;
    end else begin
      sync_chain[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= sync_chain[i-1];
      end
    end
  end

  // State register plus all clean/debounce/strobe flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= INIT;
      start_cnt    <= '0;
      clean        <= 4'b0000;
      cnt          <= '0;
      change_pulse <= 1'b0;
      ready        <= 1'b0;
    end else begin
      state        <= state_nx;
      start_cnt    <= start_cnt_nx;
      clean        <= clean_nx;
      cnt          <= cnt_nx;
      change_pulse <= pulse_nx;
      ready        <= ready_nx;
    end
  end

  // Next-state: INIT tracks the synchroniser directly, RUN debounces per bit.
  always_comb begin
    state_nx     = state;
    start_cnt_nx = start_cnt;
    clean_nx     = clean;
    cnt_nx       = cnt;
    pulse_nx     = 1'b0;
    ready_nx     = ready;
    case (state)
      INIT: begin
        // Load positions without reporting a change; counters stay idle.
        clean_nx = sync_last;
        cnt_nx   = '0;
        if (start_cnt == START_MAX) begin
          state_nx = RUN;
          ready_nx = 1'b1;
        end else begin
          start_cnt_nx = start_cnt + SW'(1);
        end
      end
      RUN: begin
        for (int i = 0; i < 4; i++) begin
          if (sync_last[i] == clean[i]) begin
            // Any return to the clean value restarts the qualification.
            cnt_nx[i] = '0;
          end else if (cnt[i] == CNT_MAX) begin
            clean_nx[i] = sync_last[i];
            cnt_nx[i]   = '0;
            pulse_nx    = 1'b1;
          end else begin
            cnt_nx[i] = cnt[i] + CW'(1);
          end
        end
      end
      default: begin
        state_nx     = INIT;
        start_cnt_nx = '0;
        cnt_nx       = '0;
        ready_nx     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): a table of
// held switch changes plus hand sequences for glitch, bounce, simultaneity and
// mid-count reset; a per-cycle monitor compares against a queue of expected
// output updates.
module tb_switch_conditioner;

  localparam int LAT = 6;   // SYNC_STAGES + DEBOUNCE_CYCLES

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_raw;
  logic [2:0] tc_raw;
  logic       mode;
  logic [2:0] tc;
  logic       pulse;
  logic       ready;

  switch_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .ModeSel_raw     (mode_raw),
    .TimeControl_raw (tc_raw),
    .ModeSel         (mode),
    .TimeControl     (tc),
    .change_pulse    (pulse),
    .ready           (ready)
  );

  always #5 clk = ~clk;

  typedef struct { int at_cyc; logic mode; logic [2:0] tc; } exp_t;
  typedef struct { logic mode; logic [2:0] tc; int hold; logic accept; } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[5];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic       mon_en = 1'b0;
  logic       cur_mode = 1'b0;
  logic [2:0] cur_tc = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive new raw levels; if the level will be held, schedule its arrival.
  task automatic drive(input logic m, input logic [2:0] t, input logic expect_update);
    mode_raw = m;
    tc_raw   = t;
    if (expect_update) sb_q.push_back('{cyc + LAT, m, t});
  endtask

  // Edge counter used to time expected updates.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pulse only with a scheduled update, outputs otherwise steady.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb_q.size() > 0 && sb_q[0].at_cyc < cyc) begin
        check("sb_timeout", cyc, sb_q[0].at_cyc);
        void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].at_cyc == cyc) begin
        cur_mode = sb_q[0].mode;
        cur_tc   = sb_q[0].tc;
        void'(sb_q.pop_front());
        check("sb_update", {pulse, mode, tc}, {1'b1, cur_mode, cur_tc});
      end else begin
        check("sb_steady", {pulse, mode, tc}, {1'b0, cur_mode, cur_tc});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 3'b111, 10, 1'b1};
    vecs[1] = '{1'b1, 3'b110, 10, 1'b1};
    vecs[2] = '{1'b0, 3'b110, 10, 1'b1};
    vecs[3] = '{1'b0, 3'b110,  5, 1'b0};
    vecs[4] = '{1'b0, 3'b010, 10, 1'b1};

    // Reset state with switches already set.
    rst = 1'b1;
    mode_raw = 1'b1;
    tc_raw   = 3'b011;
    tick(3);
    check("reset_state", {ready, pulse, mode, tc}, 6'b000000);

    // Start-up load: ready exactly LAT edges after release, no pulse.
    rst = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick(1);
      check("startup_ready", ready, (i == LAT) ? 1 : 0);
      check("startup_nopulse", pulse, 0);
    end
    check("startup_outputs", {mode, tc}, {1'b1, 3'b011});
    cur_mode = 1'b1;
    cur_tc   = 3'b011;
    mon_en   = 1'b1;

    // Held changes from the table.
    for (int v = 0; v < 5; v++) begin
      drive(vecs[v].mode, vecs[v].tc, vecs[v].accept);
      tick(vecs[v].hold);
    end

    // Glitch: 3-cycle ModeSel pulse is rejected.
    drive(1'b1, 3'b010, 1'b0);
    tick(3);
    drive(1'b0, 3'b010, 1'b0);
    tick(10);

    // Bounce on bit 0, toggling every 2 cycles, then settling at 1.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, {2'b01, (k % 2 == 0) ? 1'b1 : 1'b0}, 1'b0);
      tick(2);
    end
    drive(1'b0, 3'b011, 1'b1);
    tick(10);

    // Simultaneous change of ModeSel and bit 2: one pulse.
    drive(1'b1, 3'b111, 1'b1);
    tick(10);

    // Bit 2 bounces 2 extra cycles: two pulses 2 cycles apart.
    drive(1'b0, 3'b011, 1'b0);
    sb_q.push_back('{cyc + LAT, 1'b0, 3'b111});
    tick(1);
    drive(1'b0, 3'b111, 1'b0);
    tick(1);
    drive(1'b0, 3'b011, 1'b1);
    tick(12);

    // Acceptances on consecutive cycles give consecutive pulses.
    drive(1'b1, 3'b011, 1'b1);
    tick(1);
    drive(1'b1, 3'b001, 1'b1);
    tick(10);
    check("sb_drained", sb_q.size(), 0);

    // Reset two cycles into a pending change.
    drive(1'b0, 3'b110, 1'b0);
    tick(2);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", {ready, pulse, mode, tc}, 6'b000000);
    tick(2);
    rst = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick(1);
      check("restart_ready", ready, (i == LAT) ? 1 : 0);
      check("restart_nopulse", pulse, 0);
    end
    check("restart_outputs", {mode, tc}, {1'b0, 3'b110});
    cur_mode = 1'b0;
    cur_tc   = 3'b110;
    mon_en   = 1'b1;
    tick(8);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
